// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response port between the fetch stage and imem.
// One request outstanding; addr held stable until ready.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input  ready, rdata);
  modport slave  (input  req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues one imem request at a time and
// presents pc/pc4/ir/flush to IF/ID, honouring stalls and EX redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         redirect_valid_i,
  input  logic [31:0]  redirect_pc_i,
  fetch_unit_if.master imem,
  output logic [31:0]  pc_o,
  output logic [31:0]  pc4_o,
  output logic [31:0]  ir_o,
  output logic         flush_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} st_e;

  st_e         st_q, st_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;

  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        slot_vld;
  logic        consume;

  assign tgt      = redirect_pc_i & ~32'd3;
  assign pc_inc   = pc_q + 32'd4;
  assign slot_vld = ((st_q == REQ) && imem.ready) || (st_q == HOLD);
  assign consume  = slot_vld && !stall_i && !redirect_valid_i;

  assign pc_o      = pc_q;
  assign pc4_o     = pc_inc;
  assign imem.addr = addr_q;
  assign imem.req  = (st_q == REQ) || (st_q == DRAIN);

  // A redirect kills whatever slot is being presented this cycle.
  always_comb begin
    flush_o = 1'b1;
    ir_o    = NOP_INSN;
    if (slot_vld && !redirect_valid_i) begin
      flush_o = 1'b0;
      ir_o    = (st_q == HOLD) ? ir_q : imem.rdata;
    end
  end

  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    addr_d = addr_q;
    ir_d   = ir_q;
    unique case (st_q)
      IDLE: begin
        st_d   = REQ;
        pc_d   = redirect_valid_i ? tgt : pc_q;
        addr_d = redirect_valid_i ? tgt : pc_q;
      end
      REQ: begin
        if (redirect_valid_i) begin
          pc_d = tgt;
          if (imem.ready) addr_d = tgt;
          else            st_d   = DRAIN;   // stale handshake still has to complete
        end else if (imem.ready) begin
          if (consume) begin
            pc_d   = pc_inc;
            addr_d = pc_inc;
          end else begin
            ir_d = imem.rdata;
            st_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid_i) begin
          pc_d   = tgt;
          addr_d = tgt;
          st_d   = REQ;
        end else if (!stall_i) begin
          pc_d   = pc_inc;
          addr_d = pc_inc;
          st_d   = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid_i) pc_d = tgt;
        if (imem.ready) begin
          addr_d = redirect_valid_i ? tgt : pc_q;
          st_d   = REQ;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      ir_q   <= NOP_INSN;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      addr_q <= addr_d;
      ir_q   <= ir_d;
    end
  end

endmodule
